// File: rtl/mul32_seq.sv
// mul32_seq: 32x32 multiply sequenced as four 18x18 signed partial products on one mul_18x18.
// Optional build macro MUL32_SKIP_HH_EN: omit aH*bH and zero result[63:32] when want_high_i=0.
module mul32_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        a_signed_i,
    input  logic        b_signed_i,
    input  logic        want_high_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] result_o,
    output logic [17:0] mul_a_o,
    output logic [17:0] mul_b_o,
    input  logic [35:0] mul_p_i
);
    // state   | meaning
    // S_IDLE  | ready for a request
    // S_ISSUE | one partial product per cycle sent to the multiplier
    // S_DRAIN | waiting for outstanding products to return
    // S_DONE  | result valid, held until consumed
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int TW = MUL_LAT + 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic          sa_q, sa_d, sb_q, sb_d;
    logic          skip_q, skip_d;
    logic [1:0]    iss_cnt_q, iss_cnt_d;
    logic [17:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [TW-1:0] tag_vld_q, tag_vld_d;
    logic [1:0]    tag_k_q [TW];
    logic [1:0]    tag_k_d [TW];
    logic [63:0]   acc_q, acc_d;

    logic          skip_req;
    logic [1:0]    last_k;
    logic [17:0]   a_lo, a_hi, b_lo, b_hi;
    logic [63:0]   p_ext, p_shf;

`ifdef MUL32_SKIP_HH_EN
    assign skip_req = ~want_high_i;
`else
    logic unused_want_high;
    assign unused_want_high = want_high_i;
    assign skip_req         = 1'b0;
`endif

    assign last_k = skip_q ? 2'd2 : 2'd3;

    assign a_lo = {2'b00, a_q[15:0]};
    assign a_hi = {{2{sa_q & a_q[31]}}, a_q[31:16]};
    assign b_lo = {2'b00, b_q[15:0]};
    assign b_hi = {{2{sb_q & b_q[31]}}, b_q[31:16]};

    // Tag at the last pipe stage identifies the product currently on mul_p_i.
    assign p_ext = {{28{mul_p_i[35]}}, mul_p_i};
    always_comb begin
        p_shf = p_ext << 16;
        case (tag_k_q[MUL_LAT])
            2'd0:    p_shf = p_ext;
            2'd3:    p_shf = p_ext << 32;
            default: p_shf = p_ext << 16;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        skip_d    = skip_q;
        iss_cnt_d = iss_cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        acc_d     = acc_q;
        tag_vld_d = {tag_vld_q[TW-2:0], 1'b0};
        tag_k_d[0] = iss_cnt_q;
        for (int i = 1; i < TW; i++) begin
            tag_k_d[i] = tag_k_q[i-1];
        end

        if (tag_vld_q[MUL_LAT]) begin
            acc_d = acc_q + p_shf;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d       = op_a_i;
                    b_d       = op_b_i;
                    sa_d      = a_signed_i;
                    sb_d      = b_signed_i;
                    skip_d    = skip_req;
                    acc_d     = 64'd0;
                    iss_cnt_d = 2'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_a_d      = iss_cnt_q[1] ? a_hi : a_lo;
                mul_b_d      = iss_cnt_q[0] ? b_hi : b_lo;
                tag_vld_d[0] = 1'b1;
                iss_cnt_d    = iss_cnt_q + 2'd1;
                if (iss_cnt_q == last_k) begin
                    iss_cnt_d = 2'd0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tag_vld_q[MUL_LAT] && (tag_k_q[MUL_LAT] == last_k)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            skip_q    <= 1'b0;
            iss_cnt_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            tag_vld_q <= '0;
            acc_q     <= '0;
            for (int i = 0; i < TW; i++) begin
                tag_k_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            skip_q    <= skip_d;
            iss_cnt_q <= iss_cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            tag_vld_q <= tag_vld_d;
            acc_q     <= acc_d;
            for (int i = 0; i < TW; i++) begin
                tag_k_q[i] <= tag_k_d[i];
            end
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = skip_q ? {32'd0, acc_q[31:0]} : acc_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: drives a MUL_LAT=1 and a MUL_LAT=3 instance in lockstep, each with its own
// mul_18x18 model, and checks results against 64-bit reference arithmetic.
module tb_mul32_seq;
`ifdef MUL32_SKIP_HH_EN
    localparam bit SKIP_BUILD = 1'b1;
`else
    localparam bit SKIP_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, a_s, b_s, want_high, out_ready;
    logic [31:0] op_a, op_b;

    logic        in_ready1, out_valid1, in_ready3, out_valid3;
    logic [63:0] result1, result3;
    logic [17:0] ma1, mb1, ma3, mb3;
    logic [35:0] mp1, mp3, m3_s0, m3_s1;
    logic signed [35:0] prod1, prod3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul32_seq #(.MUL_LAT(1)) dut1 (
        .clock_i(clk), .reset_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .op_a_i(op_a), .op_b_i(op_b), .a_signed_i(a_s), .b_signed_i(b_s),
        .want_high_i(want_high), .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .result_o(result1), .mul_a_o(ma1), .mul_b_o(mb1), .mul_p_i(mp1)
    );

    mul32_seq #(.MUL_LAT(3)) dut3 (
        .clock_i(clk), .reset_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready3),
        .op_a_i(op_a), .op_b_i(op_b), .a_signed_i(a_s), .b_signed_i(b_s),
        .want_high_i(want_high), .out_valid_o(out_valid3), .out_ready_i(out_ready),
        .result_o(result3), .mul_a_o(ma3), .mul_b_o(mb3), .mul_p_i(mp3)
    );

    // mul_18x18 models: signed multiply followed by MUL_LAT register stages
    assign prod1 = $signed(ma1) * $signed(mb1);
    assign prod3 = $signed(ma3) * $signed(mb3);
    always @(posedge clk) begin
        mp1   <= prod1;
        m3_s0 <= prod3;
        m3_s1 <= m3_s0;
        mp3   <= m3_s1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic wh);
        logic [63:0] ea, eb, p;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        if (SKIP_BUILD && !wh) p[63:32] = 32'd0;
        return p;
    endfunction

    function automatic int npp_of(input logic wh);
        return (SKIP_BUILD && !wh) ? 3 : 4;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic wh,
                          input bit hold, input logic [63:0] want);
        int lat1 = -1;
        int lat3 = -1;
        int npp;
        npp = npp_of(wh);
        @(negedge clk);
        chk({tag, "_rdy1"}, {63'd0, in_ready1}, 64'd1);
        chk({tag, "_rdy3"}, {63'd0, in_ready3}, 64'd1);
        op_a = a; op_b = b; a_s = sa; b_s = sb; want_high = wh; in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        a_s       = 1'($urandom);
        b_s       = 1'($urandom);
        want_high = 1'($urandom);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) chk({tag, "_busy"}, {62'd0, in_ready1, in_ready3}, 64'd0);
            if (out_valid1 && lat1 < 0) lat1 = n;
            if (out_valid3 && lat3 < 0) lat3 = n;
            if (lat1 >= 0 && lat3 >= 0) break;
        end
        chk({tag, "_done"}, {63'd0, (lat1 >= 0 && lat3 >= 0)}, 64'd1);
        chk({tag, "_lat1"}, 64'(lat1), 64'(npp + 2));
        chk({tag, "_lat3"}, 64'(lat3), 64'(npp + 4));
        chk({tag, "_res1"}, result1, want);
        chk({tag, "_res3"}, result3, want);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk({tag, "_hold_v"}, {62'd0, out_valid1, out_valid3}, 64'd3);
                chk({tag, "_hold_r"}, {62'd0, in_ready1, in_ready3}, 64'd0);
                chk({tag, "_hold_res1"}, result1, want);
                chk({tag, "_hold_res3"}, result3, want);
                in_valid = 1'($urandom);
                op_a     = $urandom;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_v"}, {62'd0, out_valid1, out_valid3}, 64'd0);
        chk({tag, "_rel_r"}, {62'd0, in_ready1, in_ready3}, 64'd3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic rsa, rsb, rwh;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; a_s = 1'b0; b_s = 1'b0; want_high = 1'b1;
        #1;
        chk("rst_valid", {62'd0, out_valid1, out_valid3}, 64'd0);
        chk("rst_res1", result1, 64'd0);
        chk("rst_res3", result3, 64'd0);
        chk("rst_mul", {ma1, mb1, ma3, mb3}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {62'd0, in_ready1, in_ready3}, 64'd3);

        run_op("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 64'hFFFF_FFFE_0000_0001);
        run_op("ss_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 0, 64'h0000_0000_0000_0001);
        run_op("ss_min", 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 0, 64'h4000_0000_0000_0000);
        run_op("su_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 1, 64'hFFFF_FFFF_0000_0001);

        // abort mid-operation with reset
        @(negedge clk);
        op_a = 32'h1234_5678; op_b = 32'h8765_4321; a_s = 1'b1; b_s = 1'b0;
        want_high = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {62'd0, out_valid1, out_valid3}, 64'd0);
        chk("abort_res1", result1, 64'd0);
        chk("abort_res3", result3, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'd3, 32'd7, 0, 0, 1, 0, 64'd21);

`ifdef MUL32_SKIP_HH_EN
        run_op("skip_hh", 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 64'h0000_0000_242D_2080);
        run_op("keep_hh", 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1, 0,
               ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 1));
`endif

        for (int i = 0; i < 1500; i++) begin
            ra  = pick();
            rb  = pick();
            rsa = 1'($urandom);
            rsb = 1'($urandom);
            rwh = 1'($urandom);
            run_op("rand", ra, rb, rsa, rsb, rwh, ($urandom_range(0, 99) == 0),
                   ref_mul(ra, rb, rsa, rsb, rwh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
